// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer: default geometry, the control-signal
// bit that marks a register write, and the packed layout of one ROB entry.
package reorder_buffer_pkg;

    // Default geometry of the ROB and of the register tags it tracks.
    localparam int ROB_DEPTH     = 16;
    localparam int PREG_WIDTH    = 6;
    localparam int AREG_WIDTH    = 5;
    localparam int ROB_IDX_WIDTH = $clog2(ROB_DEPTH);

    // Bit position of REG_WRITE inside the decoder's c_sig control vector.
    localparam int REG_WRITE = 3;

    // Field layout of one entry at the default widths. The ROB rebuilds the
    // same layout locally so that non-default widths keep working.
    typedef struct packed {
        logic                  reg_write;
        logic [AREG_WIDTH-1:0] rd;
        logic [PREG_WIDTH-1:0] rrd;
        logic [PREG_WIDTH-1:0] old_tag;
    } rob_entry_t;

    localparam int ROB_ENTRY_WIDTH = $bits(rob_entry_t);

    // A retiring instruction hands its superseded tag back to the free pool
    // only when it really wrote a register; x0 never owns a physical tag.
    function automatic logic frees_old_tag(input logic reg_write, input logic rd_is_zero);
        return reg_write && !rd_is_zero;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of every signal exchanged between the ROB and the rename, execute
// and free-pool logic around it. The master side is the pipeline, the slave
// side is the ROB.
//
// Handshake: an allocation transfers on a cycle where alloc_valid and
// alloc_ready are both high; alloc_ready is derived from registered state only
// and never looks at alloc_valid. The pipeline must hold alloc_* stable while
// alloc_valid is high and alloc_ready is low. Completion and retire are
// single-cycle strobes with no back-pressure: complete_valid is sampled every
// edge, retire_valid/push_free_reg mean "this happens on the coming edge".
interface reorder_buffer_if #(
    parameter int DEPTH      = reorder_buffer_pkg::ROB_DEPTH,
    parameter int PREG_WIDTH = reorder_buffer_pkg::PREG_WIDTH,
    parameter int AREG_WIDTH = reorder_buffer_pkg::AREG_WIDTH,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
);
    // Allocation from rename.
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic                  alloc_reg_write;
    logic [AREG_WIDTH-1:0] alloc_rd;
    logic [PREG_WIDTH-1:0] alloc_rrd;
    logic [PREG_WIDTH-1:0] alloc_old_tag;
    logic [IDX_WIDTH-1:0]  alloc_idx;

    // Completion from execute.
    logic                  complete_valid;
    logic [IDX_WIDTH-1:0]  complete_idx;

    // Retirement and free-pool return.
    logic                  retire_valid;
    logic [AREG_WIDTH-1:0] retire_rd;
    logic [PREG_WIDTH-1:0] retire_rrd;
    logic                  push_free_reg;
    logic [PREG_WIDTH-1:0] freed_reg;

    // Occupancy.
    logic [IDX_WIDTH:0]    count;
    logic                  empty;
    logic                  full;

    modport master (
        output alloc_valid, alloc_reg_write, alloc_rd, alloc_rrd, alloc_old_tag,
        output complete_valid, complete_idx,
        input  alloc_ready, alloc_idx,
        input  retire_valid, retire_rd, retire_rrd, push_free_reg, freed_reg,
        input  count, empty, full
    );

    modport slave (
        input  alloc_valid, alloc_reg_write, alloc_rd, alloc_rrd, alloc_old_tag,
        input  complete_valid, complete_idx,
        output alloc_ready, alloc_idx,
        output retire_valid, retire_rd, retire_rrd, push_free_reg, freed_reg,
        output count, empty, full
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer sitting right after rename. Entries are
// allocated at the tail, marked done out of order by index, and retired one
// per cycle from the head, returning the superseded physical tag to the free
// pool. Occupancy is tracked by an explicit counter so that full and empty
// never depend on comparing the wrapping pointers.
module reorder_buffer #(
    parameter int DEPTH      = reorder_buffer_pkg::ROB_DEPTH,
    parameter int PREG_WIDTH = reorder_buffer_pkg::PREG_WIDTH,
    parameter int AREG_WIDTH = reorder_buffer_pkg::AREG_WIDTH,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,   // asynchronous, active-low
    reorder_buffer_if.slave rob
);
    import reorder_buffer_pkg::*;

    // DEPTH must be a power of two so the pointers wrap by plain overflow.
    localparam logic [IDX_WIDTH:0] FULL_COUNT = DEPTH[IDX_WIDTH:0];

    typedef struct packed {
        logic                  reg_write;
        logic [AREG_WIDTH-1:0] rd;
        logic [PREG_WIDTH-1:0] rrd;
        logic [PREG_WIDTH-1:0] old_tag;
    } entry_t;

    // Per-entry status bits (reset) and payload (no reset: only read while valid).
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     done_q,  done_d;
    entry_t               entry_q [DEPTH];

    logic [IDX_WIDTH-1:0] head_q, head_d;
    logic [IDX_WIDTH-1:0] tail_q, tail_d;
    logic [IDX_WIDTH:0]   count_q, count_d;

    logic                 full_w;
    logic                 empty_w;
    logic                 alloc_fire;
    logic                 complete_hit;
    logic                 retire_fire;
    entry_t               head_entry;

    // Occupancy flags come from the registered count only, so a retire in the
    // same cycle never opens a slot for an allocation while full.
    assign full_w  = (count_q == FULL_COUNT);
    assign empty_w = (count_q == '0);

    assign alloc_fire   = rob.alloc_valid && !full_w;
    assign complete_hit = rob.complete_valid && valid_q[rob.complete_idx];
    assign head_entry   = entry_q[head_q];
    assign retire_fire  = valid_q[head_q] && done_q[head_q];

    // Pipeline-facing outputs; retire fields are forced to zero when idle.
    assign rob.alloc_ready   = !full_w;
    assign rob.alloc_idx     = tail_q;
    assign rob.retire_valid  = retire_fire;
    assign rob.retire_rd     = retire_fire ? head_entry.rd      : '0;
    assign rob.retire_rrd    = retire_fire ? head_entry.rrd     : '0;
    assign rob.freed_reg     = retire_fire ? head_entry.old_tag : '0;
    assign rob.push_free_reg = retire_fire &&
                               frees_old_tag(head_entry.reg_write, head_entry.rd == '0);
    assign rob.count         = count_q;
    assign rob.empty         = empty_w;
    assign rob.full          = full_w;

    // Next-state of the status bits. A completion only lands on a live entry;
    // it cannot hit the slot being allocated (that slot is not valid yet) and
    // a completion of the head in the same cycle just becomes visible next cycle.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (complete_hit) begin
            done_d[rob.complete_idx] = 1'b1;
        end
        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
        end
        if (retire_fire) begin
            valid_d[head_q] = 1'b0;
        end
    end

    // Next-state of pointers and occupancy; simultaneous alloc and retire
    // move both pointers and leave the count alone.
    always_comb begin
        head_d  = retire_fire ? head_q + 1'b1 : head_q;
        tail_d  = alloc_fire  ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        unique case ({alloc_fire, retire_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state: asynchronous reset discards every entry at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload captured at allocation.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            entry_q[tail_q] <= '{
                reg_write: rob.alloc_reg_write,
                rd:        rob.alloc_rd,
                rrd:       rob.alloc_rrd,
                old_tag:   rob.alloc_old_tag
            };
        end
    end

    // Structural invariants of the occupancy bookkeeping.
    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count_q <= FULL_COUNT);
    a_count_matches_valid: assert property (@(posedge clk) disable iff (!rst)
        $countones(valid_q) == int'(count_q));
    a_retire_nonempty: assert property (@(posedge clk) disable iff (!rst)
        retire_fire |-> !empty_w);

endmodule
